// File: rtl/rs_lock_mon_pkg.sv
// Shared constants for the RS-FEC codeword lock monitor: FSM encodings,
// default lock/unlock thresholds and datapath widths.
package rs_lock_mon_pkg;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } lock_state_e;

    localparam int unsigned CW_BEATS_DEF   = 24;
    localparam int unsigned LOCK_CNT_DEF   = 4;
    localparam int unsigned UNLOCK_CNT_DEF = 3;
    localparam int unsigned SLIP_BLANK_DEF = 2;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BEAT_W    = 5;
    localparam int unsigned CW_CNT_W  = 32;
    localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/rs_lock_mon_sat_cnt.sv
// Saturating statistics counter; a clear wins over a same-cycle increment.
module rs_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rs_lock_mon.sv
// Codeword lock monitor behind the RS-FEC decoder: delineates decoder bursts,
// attributes failures per codeword, runs the lock FSM and keeps statistics.
module rs_lock_mon
    import rs_lock_mon_pkg::*;
#(
    parameter int unsigned CW_BEATS   = CW_BEATS_DEF,
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
    parameter int unsigned SLIP_BLANK = SLIP_BLANK_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rsfec_ena,
    input  logic                 dec_data_vld,
    input  logic [DATA_W-1:0]    dec_data,
    input  logic                 dec_isos,
    input  logic                 rde_error,
    input  logic                 stat_clr,
    output logic                 mon_data_vld,
    output logic [DATA_W-1:0]    mon_data,
    output logic                 mon_isos,
    output logic                 rs_lock,
    output logic                 rs_slip,
    output logic [CW_CNT_W-1:0]  cw_cnt,
    output logic [ERR_CNT_W-1:0] fail_cnt,
    output logic [ERR_CNT_W-1:0] len_err_cnt
);

    localparam int unsigned CNT_W = $clog2(LOCK_CNT + UNLOCK_CNT + SLIP_BLANK + 1);

    logic              vld_1t_q;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              fail_sticky_q, fail_sticky_d;
    lock_state_e       state_q;
    logic [CNT_W-1:0]  good_cnt_q, bad_cnt_q, blank_cnt_q;
    logic [CNT_W-1:0]  good_inc, bad_inc, blank_inc;
    logic              rs_lock_q, rs_slip_q;
    logic              mon_vld_q, mon_isos_q;
    logic [DATA_W-1:0] mon_data_q;

    logic cw_end, len_fail, cw_fail;

    assign cw_end    = vld_1t_q & ~dec_data_vld;
    assign len_fail  = (beat_cnt_q != BEAT_W'(CW_BEATS));
    assign cw_fail   = fail_sticky_q | rde_error | len_fail;
    assign good_inc  = good_cnt_q + CNT_W'(1);
    assign bad_inc   = bad_cnt_q + CNT_W'(1);
    assign blank_inc = blank_cnt_q + CNT_W'(1);

    // Burst length and failure attribution for the codeword in flight
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (cw_end) begin
            beat_cnt_d = dec_data_vld ? BEAT_W'(1) : '0;
        end else if (dec_data_vld && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end

        fail_sticky_d = fail_sticky_q;
        if (!rsfec_ena || cw_end) begin
            fail_sticky_d = 1'b0;
        end else if (rde_error) begin
            fail_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_1t_q      <= 1'b0;
            beat_cnt_q    <= '0;
            fail_sticky_q <= 1'b0;
            mon_vld_q     <= 1'b0;
            mon_isos_q    <= 1'b0;
            mon_data_q    <= '0;
        end else begin
            vld_1t_q      <= dec_data_vld;
            beat_cnt_q    <= beat_cnt_d;
            fail_sticky_q <= fail_sticky_d;
            mon_vld_q     <= dec_data_vld;
            mon_isos_q    <= dec_isos;
            if (dec_data_vld) begin
                mon_data_q <= dec_data;
            end
        end
    end

    // Lock FSM; only codeword boundaries move it, disable parks it in HUNT
    always_ff @(posedge clk) begin
        if (!rstn || !rsfec_ena) begin
            state_q     <= ST_HUNT;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            blank_cnt_q <= '0;
            rs_lock_q   <= 1'b0;
            rs_slip_q   <= 1'b0;
        end else begin
            rs_slip_q <= 1'b0;
            if (cw_end) begin
                case (state_q)
                    ST_HUNT: begin
                        if (cw_fail) begin
                            rs_slip_q   <= 1'b1;
                            good_cnt_q  <= '0;
                            blank_cnt_q <= '0;
                            state_q     <= ST_SLIP_WAIT;
                        end else begin
                            good_cnt_q <= good_inc;
                            if (good_inc == CNT_W'(LOCK_CNT)) begin
                                bad_cnt_q <= '0;
                                rs_lock_q <= 1'b1;
                                state_q   <= ST_LOCKED;
                            end
                        end
                    end
                    ST_SLIP_WAIT: begin
                        blank_cnt_q <= blank_inc;
                        if (blank_inc == CNT_W'(SLIP_BLANK)) begin
                            good_cnt_q <= '0;
                            state_q    <= ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        if (cw_fail) begin
                            bad_cnt_q <= bad_inc;
                            if (bad_inc == CNT_W'(UNLOCK_CNT)) begin
                                good_cnt_q <= '0;
                                rs_lock_q  <= 1'b0;
                                state_q    <= ST_HUNT;
                            end
                        end else begin
                            bad_cnt_q <= '0;
                        end
                    end
                    default: begin
                        rs_lock_q <= 1'b0;
                        state_q   <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    rs_sat_cnt #(.W(CW_CNT_W)) u_cw_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (stat_clr),
        .inc_i  (cw_end & rsfec_ena),
        .cnt_o  (cw_cnt)
    );

    rs_sat_cnt #(.W(ERR_CNT_W)) u_fail_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (stat_clr),
        .inc_i  (cw_end & rsfec_ena & cw_fail),
        .cnt_o  (fail_cnt)
    );

    rs_sat_cnt #(.W(ERR_CNT_W)) u_len_err_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (stat_clr),
        .inc_i  (cw_end & rsfec_ena & len_fail),
        .cnt_o  (len_err_cnt)
    );

    assign mon_data_vld = mon_vld_q;
    assign mon_data     = mon_data_q;
    assign mon_isos     = mon_isos_q;
    assign rs_lock      = rs_lock_q;
    assign rs_slip      = rs_slip_q;

endmodule

// File: tb/tb_rs_lock_mon.sv
// Directed bench for rs_lock_mon: pass-through data and slip requests are
// scoreboarded by monitors, lock status and counters are checked at fixed points.
module tb_rs_lock_mon;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rsfec_ena;
    logic        dec_data_vld;
    logic [63:0] dec_data;
    logic        dec_isos;
    logic        rde_error;
    logic        stat_clr;
    logic        mon_data_vld;
    logic [63:0] mon_data;
    logic        mon_isos;
    logic        rs_lock;
    logic        rs_slip;
    logic [31:0] cw_cnt;
    logic [15:0] fail_cnt;
    logic [15:0] len_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bid    = 0;
    bit slip_prev = 1'b0;

    logic [64:0] data_q[$];
    int          slip_q[$];

    rs_lock_mon dut (
        .clk          (clk),
        .rstn         (rstn),
        .rsfec_ena    (rsfec_ena),
        .dec_data_vld (dec_data_vld),
        .dec_data     (dec_data),
        .dec_isos     (dec_isos),
        .rde_error    (rde_error),
        .stat_clr     (stat_clr),
        .mon_data_vld (mon_data_vld),
        .mon_data     (mon_data),
        .mon_isos     (mon_isos),
        .rs_lock      (rs_lock),
        .rs_slip      (rs_slip),
        .cw_cnt       (cw_cnt),
        .fail_cnt     (fail_cnt),
        .len_err_cnt  (len_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_stat(input string tag, input bit lock, input int cw, input int fl, input int le);
        chk({tag, "_lock"}, 64'(rs_lock), 64'(lock));
        chk({tag, "_cw_cnt"}, 64'(cw_cnt), 64'(cw));
        chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(fl));
        chk({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(le));
    endtask

    // Drives n beats then one idle cycle; returns inside the cw_end cycle (T+1)
    task automatic send_burst(input int n, input int err_beat, input bit exp_slip);
        int c_last = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            dec_data_vld = 1'b1;
            dec_data     = {32'(bid), 32'(i)};
            dec_isos     = (i == 0);
            rde_error    = (i == err_beat);
            data_q.push_back({dec_isos, dec_data});
            c_last = cyc;
        end
        @(posedge clk); #1;
        dec_data_vld = 1'b0;
        dec_isos     = 1'b0;
        rde_error    = 1'b0;
        dec_data     = '0;
        if (exp_slip) slip_q.push_back(c_last + 2);
        bid++;
    endtask

    // Pass-through scoreboard
    always @(negedge clk) begin
        if (rstn === 1'b1 && mon_data_vld === 1'b1) begin
            if (data_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon_unexpected: got beat %0h, expected none", mon_data);
            end else begin
                logic [64:0] e;
                e = data_q.pop_front();
                chk("mon_data", mon_data, e[63:0]);
                chk("mon_isos", 64'(mon_isos), 64'(e[64]));
            end
        end
    end

    // Slip scoreboard: expected cycle of each slip pulse, never two in a row
    always @(negedge clk) begin
        if (rstn === 1'b1 && rs_slip === 1'b1) begin
            if (slip_prev) begin
                n_chk++;
                n_fail++;
                $display("FAIL slip_consecutive: got 2 cycles, expected 1 (cycle %0d)", cyc);
            end
            if (slip_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL slip_unexpected: got slip at cycle %0d, expected none", cyc);
            end else begin
                chk("slip_cycle", 64'(cyc), 64'(slip_q.pop_front()));
            end
        end
        slip_prev = (rs_slip === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; rsfec_ena = 1'b1; dec_data_vld = 1'b0; dec_data = '0;
        dec_isos = 1'b0; rde_error = 1'b0; stat_clr = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_stat("reset", 1'b0, 0, 0, 0);
        chk("reset_slip", 64'(rs_slip), 64'd0);
        chk("reset_mon_vld", 64'(mon_data_vld), 64'd0);
        chk("reset_mon_data", mon_data, 64'd0);
        rstn = 1'b1;

        // Lock after four clean codewords
        repeat (3) send_burst(24, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("lock_after3", 64'(rs_lock), 64'd0);
        send_burst(24, -1, 1'b0);
        @(negedge clk);
        chk("lock_t1", 64'(rs_lock), 64'd0);
        @(negedge clk);
        chk_stat("lock4", 1'b1, 4, 0, 0);

        // Enable drop forces HUNT next cycle, counters hold
        @(posedge clk); #1 rsfec_ena = 1'b0;
        @(negedge clk);
        chk("ena_same_cycle", 64'(rs_lock), 64'd1);
        @(posedge clk); #1 rsfec_ena = 1'b1;
        @(negedge clk);
        chk_stat("ena_drop1", 1'b0, 4, 0, 0);

        // Slip in HUNT, two blanked codewords (first failing), then relock
        send_burst(24, 10, 1'b1);
        @(negedge clk); @(negedge clk);
        chk_stat("slip", 1'b0, 5, 1, 0);
        send_burst(24, 3, 1'b0);
        send_burst(24, -1, 1'b0);
        repeat (3) send_burst(24, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("relock_after3", 64'(rs_lock), 64'd0);
        send_burst(24, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk_stat("relock", 1'b1, 11, 2, 0);

        // Unlock: F F G F F F, no slip on unlock
        send_burst(24, 5, 1'b0);
        send_burst(24, 5, 1'b0);
        send_burst(24, -1, 1'b0);
        send_burst(24, 5, 1'b0);
        send_burst(24, 5, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("unlock_2fail", 64'(rs_lock), 64'd1);
        send_burst(24, 5, 1'b0);
        @(negedge clk);
        chk("unlock_t1", 64'(rs_lock), 64'd1);
        @(negedge clk);
        chk_stat("unlock", 1'b0, 17, 7, 0);

        // Length errors: 23 beats slips from HUNT, 25 beats is blanked
        send_burst(23, -1, 1'b1);
        send_burst(25, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk_stat("len_err", 1'b0, 19, 9, 2);

        // Stray rde_error between bursts is charged to the next codeword
        @(posedge clk); #1 rde_error = 1'b1;
        @(posedge clk); #1 rde_error = 1'b0;
        send_burst(24, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk_stat("stray", 1'b0, 20, 10, 2);

        // stat_clr coincident with cw_end wins over the increment
        send_burst(24, -1, 1'b0);
        stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        chk_stat("clr", 1'b0, 0, 0, 0);

        // Good codewords 2..4 after the clear reach lock
        repeat (3) send_burst(24, -1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk_stat("lock_post_clr", 1'b1, 3, 0, 0);

        // Enable drop while locked, then pass-through with FEC disabled
        @(posedge clk); #1 rsfec_ena = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_stat("ena_drop2", 1'b0, 3, 0, 0);
        @(posedge clk); #1;
        dec_data_vld = 1'b1;
        dec_data     = 64'hA5A5_0000_FFFF_1234;
        dec_isos     = 1'b0;
        data_q.push_back({1'b0, 64'hA5A5_0000_FFFF_1234});
        @(posedge clk); #1;
        dec_data_vld = 1'b0;
        dec_data     = '0;
        @(negedge clk);
        chk("pt_mon_data", mon_data, 64'hA5A5_0000_FFFF_1234);
        chk("pt_mon_vld", 64'(mon_data_vld), 64'd1);
        @(negedge clk);
        chk_stat("pt_hold", 1'b0, 3, 0, 0);
        chk("pt_mon_vld_low", 64'(mon_data_vld), 64'd0);
        rsfec_ena = 1'b1;

        repeat (4) @(negedge clk);
        chk("data_q_left", 64'(data_q.size()), 64'd0);
        chk("slip_q_left", 64'(slip_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
